// File: rtl/fifo_panel_ctrl_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | fifo_panel_ctrl_pkg : shared defaults and FSM encoding            |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package fifo_panel_ctrl_pkg;

  localparam int c_WIDTH_DEFAULT    = 4;
  localparam int c_DEB_BITS_DEFAULT = 20;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD       = 3'd2,
    ST_RD_CAP   = 3'd3,
    ST_WAIT_REL = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | btn_debounce : 2-flop synchroniser, saturating debounce, press    |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module btn_debounce #(
  parameter int DEB_BITS = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam logic [DEB_BITS-1:0] c_CNT_MAX = {DEB_BITS{1'b1}};
  localparam logic [DEB_BITS-1:0] c_CNT_ONE = DEB_BITS'(1);

  logic                r_sync1;
  logic                r_sync2;
  logic                r_prev;
  logic                r_level;
  logic                r_press;
  logic [DEB_BITS-1:0] r_cnt;
  logic                w_level_nxt;

  // The sample is trusted only once the counter has saturated.
  assign w_level_nxt = (r_cnt == c_CNT_MAX) ? r_prev : r_level;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_sync2 != r_prev) begin
        r_cnt <= '0;
      end else if (r_cnt != c_CNT_MAX) begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
      r_level <= w_level_nxt;
      r_press <= r_level & ~w_level_nxt;
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/fifo_panel_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | fifo_panel_ctrl : push-button panel driving a FIFO write/read port|
// | Option macro PANEL_ERR_STICKY_EN makes err hold until reset.      |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module fifo_panel_ctrl
  import fifo_panel_ctrl_pkg::*;
#(
  parameter int WIDTH    = c_WIDTH_DEFAULT,
  parameter int DEB_BITS = c_DEB_BITS_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             read_btn,
  input  logic             write_btn,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_wr_en,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] fifo_wr_data,
  output logic [WIDTH-1:0] disp_data,
  output logic             busy,
  output logic             err
);

  logic w_wr_level;
  logic w_wr_press;
  logic w_rd_level;
  logic w_rd_press;

  btn_debounce #(.DEB_BITS(DEB_BITS)) u_deb_wr (
    .clock (clock),
    .reset (reset),
    .btn   (write_btn),
    .level (w_wr_level),
    .press (w_wr_press)
  );

  btn_debounce #(.DEB_BITS(DEB_BITS)) u_deb_rd (
    .clock (clock),
    .reset (reset),
    .btn   (read_btn),
    .level (w_rd_level),
    .press (w_rd_press)
  );

  state_t           r_state;
  logic             r_pend;
  logic             r_wr_en;
  logic             r_rd_en;
  logic [WIDTH-1:0] r_wr_data;
  logic [WIDTH-1:0] r_disp;
  logic             r_busy;
  logic             r_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pend    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_wr_data <= '0;
      r_disp    <= '0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
`ifdef PANEL_ERR_STICKY_EN
      r_err   <= r_err;
`else
      r_err   <= 1'b0;
`endif
      unique case (r_state)
        ST_IDLE: begin
          if (w_wr_press) begin
            r_state <= ST_WR;
            r_busy  <= 1'b1;
            r_pend  <= w_rd_press;
          end else if (w_rd_press) begin
            r_state <= ST_RD;
            r_busy  <= 1'b1;
          end
        end
        ST_WR: begin
          if (!fifo_full) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= sw_in;
          end else begin
            r_err <= 1'b1;
          end
          r_state <= r_pend ? ST_RD : ST_WAIT_REL;
        end
        ST_RD: begin
          if (!fifo_empty) begin
            r_rd_en <= 1'b1;
            r_state <= ST_RD_CAP;
          end else begin
            r_err   <= 1'b1;
            r_pend  <= 1'b0;
            r_state <= ST_WAIT_REL;
          end
        end
        ST_RD_CAP: begin
          // Read data lands the cycle after the strobe, so wait for it to drop.
          if (!r_rd_en) begin
            r_disp  <= fifo_rd_data;
            r_pend  <= 1'b0;
            r_state <= ST_WAIT_REL;
          end
        end
        ST_WAIT_REL: begin
          if (w_wr_level && w_rd_level) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_pend  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_wr_en   = r_wr_en;
  assign fifo_rd_en   = r_rd_en;
  assign fifo_wr_data = r_wr_data;
  assign disp_data    = r_disp;
  assign busy         = r_busy;
  assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_panel_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_fifo_panel_ctrl : randomized button sequences vs queue model   |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tb_fifo_panel_ctrl;

  localparam int WIDTH    = 4;
  localparam int DEB_BITS = 4;
  localparam int DEPTH    = 4;

  logic             clock     = 1'b0;
  logic             reset     = 1'b1;
  logic             read_btn  = 1'b1;
  logic             write_btn = 1'b1;
  logic [WIDTH-1:0] sw_in     = '0;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rd_data = '0;
  logic             fifo_wr_en;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_wr_data;
  logic [WIDTH-1:0] disp_data;
  logic             busy;
  logic             err;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  fifo_panel_ctrl #(.WIDTH(WIDTH), .DEB_BITS(DEB_BITS)) dut (
    .clock        (clock),
    .reset        (reset),
    .read_btn     (read_btn),
    .write_btn    (write_btn),
    .sw_in        (sw_in),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_wr_data (fifo_wr_data),
    .disp_data    (disp_data),
    .busy         (busy),
    .err          (err)
  );

  // Environment FIFO: flags reflect contents before the current edge.
  logic [WIDTH-1:0] mem [DEPTH];
  int fcnt = 0;
  int frp  = 0;
  int fwp  = 0;

  always @(posedge clock) begin
    if (fifo_wr_en && fcnt < DEPTH) begin
      mem[fwp] <= fifo_wr_data;
      fwp      <= (fwp + 1) % DEPTH;
    end
    if (fifo_rd_en && fcnt > 0) begin
      fifo_rd_data <= mem[frp];
      frp          <= (frp + 1) % DEPTH;
    end
    fcnt <= fcnt + ((fifo_wr_en && fcnt < DEPTH) ? 1 : 0) - ((fifo_rd_en && fcnt > 0) ? 1 : 0);
  end

  assign fifo_full  = (fcnt == DEPTH);
  assign fifo_empty = (fcnt == 0);

  // Running event counters; each operation diffs them.
  int               cyc    = 0;
  int               n_wr   = 0;
  int               n_rd   = 0;
  int               n_err  = 0;
  int               n_ovl  = 0;
  int               n_rep  = 0;
  int               rd_cyc = -10;
  logic [WIDTH-1:0] last_wr_data = '0;
  logic [WIDTH-1:0] disp_at2     = '0;
  logic             busy_at_wr   = 1'b0;
  logic             prev_wr      = 1'b0;
  logic             prev_rd      = 1'b0;

  always @(negedge clock) begin
    cyc++;
    if (fifo_wr_en) begin
      n_wr++;
      last_wr_data = fifo_wr_data;
      busy_at_wr   = busy;
    end
    if (fifo_rd_en) begin
      n_rd++;
      rd_cyc = cyc;
    end
    if (cyc == rd_cyc + 2) disp_at2 = disp_data;
    if (err) n_err++;
    if (fifo_wr_en && fifo_rd_en) n_ovl++;
    if ((fifo_wr_en && prev_wr) || (fifo_rd_en && prev_rd)) n_rep++;
    prev_wr = fifo_wr_en;
    prev_rd = fifo_rd_en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] exp_disp   = '0;
  bit               exp_sticky = 1'b0;

  task automatic do_op(input bit wr, input bit rd, input logic [WIDTH-1:0] sw, input bit bounce);
    int               w0;
    int               r0;
    int               e0;
    int               refusals;
    bit               wr_ok;
    bit               rd_ok;
    logic [WIDTH-1:0] rd_val;
    w0       = n_wr;
    r0       = n_rd;
    e0       = n_err;
    refusals = 0;
    rd_val   = '0;
    // Read decision sees the FIFO as it was before any write of this op.
    wr_ok = wr && (model_q.size() < DEPTH);
    rd_ok = rd && (model_q.size() > 0);
    if (rd_ok) rd_val = model_q[0];
    if (wr && !wr_ok) refusals++;
    if (rd && !rd_ok) refusals++;

    @(negedge clock);
    sw_in = sw;
    if (bounce) begin
      for (int i = 0; i < 5; i++) begin
        write_btn = ~wr;
        read_btn  = ~rd;
        @(negedge clock);
        write_btn = 1'b1;
        read_btn  = 1'b1;
        @(negedge clock);
      end
    end
    write_btn = ~wr;
    read_btn  = ~rd;
    repeat (30) @(negedge clock);
    check("busy_hold", busy, 1);
    write_btn = 1'b1;
    read_btn  = 1'b1;
    repeat (30) @(negedge clock);

    check("wr_count", n_wr - w0, wr_ok);
    if (wr_ok) begin
      check("wr_data", last_wr_data, sw);
      check("busy_at_wr", busy_at_wr, 1);
    end
    check("rd_count", n_rd - r0, rd_ok);
    if (rd_ok) begin
      check("disp_2cyc", disp_at2, rd_val);
      exp_disp = rd_val;
    end
    check("disp", disp_data, exp_disp);
`ifdef PANEL_ERR_STICKY_EN
    if (refusals > 0) exp_sticky = 1'b1;
    check("err_level", err, exp_sticky);
`else
    check("err_pulses", n_err - e0, refusals);
`endif
    check("busy_idle", busy, 0);
    check("no_overlap", n_ovl, 0);
    check("no_repeat", n_rep, 0);

    if (wr_ok) model_q.push_back(sw);
    if (rd_ok) void'(model_q.pop_front());
  endtask

  initial begin
    int k;
    int t;
    int w0;
    int r0;

    repeat (3) @(negedge clock);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_wr_data", fifo_wr_data, 0);
    check("rst_disp", disp_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    repeat (30) @(negedge clock);

    do_op(1'b1, 1'b0, 4'hA, 1'b0);
    do_op(1'b1, 1'b0, 4'h3, 1'b1);
    do_op(1'b0, 1'b1, 4'h0, 1'b0);
    do_op(1'b0, 1'b1, 4'h0, 1'b0);
    do_op(1'b0, 1'b1, 4'h0, 1'b0);
    do_op(1'b1, 1'b0, 4'h3, 1'b0);
    do_op(1'b1, 1'b1, 4'h5, 1'b0);

    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(0, 3);
      do_op(k != 1, k == 1 || k == 2, WIDTH'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset while WR is active with a read pending.
    @(negedge clock);
    write_btn = 1'b0;
    read_btn  = 1'b0;
    t = 0;
    while (!busy && t < 60) begin
      @(negedge clock);
      t++;
    end
    check("busy_before_rst", busy, 1);
    w0 = n_wr;
    r0 = n_rd;
    #1 reset = 1'b1;
    #1;
    check("arst_wr_en", fifo_wr_en, 0);
    check("arst_rd_en", fifo_rd_en, 0);
    check("arst_wr_data", fifo_wr_data, 0);
    check("arst_disp", disp_data, 0);
    check("arst_busy", busy, 0);
    check("arst_err", err, 0);
    write_btn = 1'b1;
    read_btn  = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("arst_no_wr", n_wr - w0, 0);
    check("arst_no_rd", n_rd - r0, 0);
    check("arst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
